// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared types and constants for the integer mul/div unit
package mul_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = '1;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_sign_fixup.sv
// rtl/div_sign_fixup.sv - conditional two's-complement negate
module div_sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module divider_iter
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  div_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             qsign_q, qsign_d, rsign_q, rsign_d;

  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   r_wide, diff;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_quo, fix_sel, fixed;
  logic             fix_neg;

  assign in_signed = ~in_op[0];

  div_sign_fixup #(.WIDTH(WIDTH)) u_abs_a (
    .val_i(in_a), .neg_i(in_signed & in_a[WIDTH-1]), .val_o(abs_a));
  div_sign_fixup #(.WIDTH(WIDTH)) u_abs_b (
    .val_i(in_b), .neg_i(in_signed & in_b[WIDTH-1]), .val_o(abs_b));

  // The bit shifted out of rem_q still counts: with it set, R exceeds any divisor.
  assign r_wide   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = r_wide - {1'b0, dvs_q};
  assign ge       = rem_q[WIDTH-1] | ~diff[WIDTH];
  assign step_rem = ge ? diff[WIDTH-1:0] : r_wide[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ge};

  assign fix_sel = op_q[1] ? step_rem : step_quo;
  assign fix_neg = ~op_q[0] & (op_q[1] ? rsign_q : qsign_q);

  div_sign_fixup #(.WIDTH(WIDTH)) u_fix_res (
    .val_i(fix_sel), .neg_i(fix_neg), .val_o(fixed));

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    tag_d    = tag_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = div_op_t'(in_op);
          tag_d   = in_tag;
          qsign_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          rsign_d = in_a[WIDTH-1];
          if (in_b == '0) begin
            result_d = in_op[1] ? in_a : DIV_BY_ZERO_Q;
            state_d  = DONE;
          end else if (in_signed && in_a == SIGNED_MIN && in_b == '1) begin
            result_d = in_op[1] ? '0 : SIGNED_MIN;
            state_d  = DONE;
          end else begin
            quo_d   = abs_a;
            rem_d   = '0;
            dvs_d   = abs_b;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_d = fixed;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
    end
  end

endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - self-checking bench for divider_iter
module tb_divider_iter;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_iter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V semantics from plain 64-bit arithmetic; overflow falls out of truncation.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      4: v = 32'($urandom_range(0, 20));
      5: v = 32'h8000_0000 | 32'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("issue_ready", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 80) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
    int lat;
    issue(op, a, b, tag);
    wait_valid(lat);
    check({name, "_lat"}, lat, ref_lat(op, a, b));
    check({name, "_res"}, out_result, ref_div(op, a, b));
    check({name, "_tag"}, out_tag, tag);
    check({name, "_busy_rdy"}, in_ready, 0);
    handoff();
    check({name, "_post_rdy"}, in_ready, 1);
    check({name, "_post_vld"}, out_valid, 0);
  endtask

  initial begin
    int lat, seen;
    logic [31:0] r0;
    logic [4:0]  t0;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_check("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3);
    run_check("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd3);
    run_check("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_check("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_check("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6);
    run_check("divu_by0", 2'b01, 32'd5, 32'd0, 5'd7);
    run_check("remu_by0", 2'b11, 32'd5, 32'd0, 5'd8);
    run_check("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_check("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_check("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11);

    // backpressure
    issue(2'b01, 32'd1000, 32'd9, 5'd21);
    wait_valid(lat);
    check("bp_lat", lat, 33);
    r0 = out_result; t0 = out_tag;
    check("bp_res", r0, 32'd111);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", out_result, r0);
      check("bp_hold_tag", out_tag, t0);
      check("bp_hold_rdy", in_ready, 0);
      check("bp_hold_vld", out_valid, 1);
    end
    handoff();
    check("bp_post_rdy", in_ready, 1);

    // flush during BUSY
    issue(2'b01, 32'hDEAD_BEEF, 32'h13, 5'd12);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_rdy", in_ready, 1);
    check("flush_busy_vld", out_valid, 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_busy_quiet", seen, 0);
    run_check("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd13);

    // flush together with an accept discards the accept
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd50; in_b = 32'd0; in_tag = 5'd14; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc_rdy", in_ready, 1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_acc_quiet", seen, 0);

    // flush in DONE while stalled
    issue(2'b00, 32'd77, 32'd7, 5'd15);
    wait_valid(lat);
    check("flush_done_lat", lat, 33);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_vld", out_valid, 0);
    check("flush_done_rdy", in_ready, 1);

    // async reset mid-BUSY
    issue(2'b01, 32'd1000, 32'd3, 5'd17);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_vld", out_valid, 0);
    check("arst_rdy", in_ready, 1);
    check("arst_res", out_result, 0);
    check("arst_tag", out_tag, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 1200; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tg;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      tg = 5'($urandom_range(0, 31));
      issue(op, a, b, tg);
      wait_valid(lat);
      check("rnd_lat", lat, ref_lat(op, a, b));
      check("rnd_res", out_result, ref_div(op, a, b));
      check("rnd_tag", out_tag, tg);
      out_ready = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
